// File: rtl/hazard_fwd_unit.sv
// rtl/hazard_fwd_unit.sv - ID-stage data-hazard and operand forwarding controller
// Optional feature macro: HAZ_PERF_EN (adds the stall_cycles counter port)
module hazard_fwd_unit #(
  parameter int REG_AW   = 5,
  parameter int NUM_SRC  = 2,
  parameter int LOAD_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC*REG_AW-1:0] src_addr,
  input  logic [NUM_SRC-1:0]        src_used,
  input  logic [REG_AW-1:0]         ex_rd,
  input  logic                      ex_we,
  input  logic                      ex_load,
  input  logic [REG_AW-1:0]         mem_rd,
  input  logic                      mem_we,
  input  logic [REG_AW-1:0]         wb_rd,
  input  logic                      wb_we,
  input  logic                      mem_busy,
  input  logic                      flush,
  output logic [2*NUM_SRC-1:0]      fwd_sel,
  output logic                      stall,
  output logic                      nop
`ifdef HAZ_PERF_EN
  ,
  output logic [31:0]               stall_cycles
`endif
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_LWAIT = 2'd1;
  localparam logic [3:0] LAT_M1   = 4'(LOAD_LAT - 1);

  logic [1:0]           state, state_d;
  logic [3:0]           cnt, cnt_d;
  logic [NUM_SRC-1:0]   m_ex, m_mem, m_wb;
  logic [2*NUM_SRC-1:0] fwd_raw;
  logic                 luse;
  logic                 stall_raw, nop_raw;

  // Per-operand match against each later stage; GR0 and unread operands never match
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [REG_AW-1:0] a;
    logic              v;
    assign a = src_addr[i*REG_AW +: REG_AW];
    assign v = src_used[i] && (a != '0);
    assign m_ex[i]  = v && ex_we  && (a == ex_rd);
    assign m_mem[i] = v && mem_we && (a == mem_rd);
    assign m_wb[i]  = v && wb_we  && (a == wb_rd);
    // Youngest producer wins
    assign fwd_raw[2*i +: 2] = m_ex[i]  ? 2'b01 :
                               m_mem[i] ? 2'b10 :
                               m_wb[i]  ? 2'b11 : 2'b00;
  end

  assign luse = ex_load && ex_we && (|m_ex);

  // Stall/bubble decode: flush beats mem_busy beats load wait beats new load-use
  always_comb begin
    stall_raw = 1'b0;
    nop_raw   = 1'b0;
    if (flush) begin
      nop_raw = 1'b1;
    end else if (mem_busy) begin
      stall_raw = 1'b1;
    end else if (state == ST_LWAIT || luse) begin
      stall_raw = 1'b1;
      nop_raw   = 1'b1;
    end
  end

  // Outputs are held at zero while reset is asserted, independent of the clock
  assign stall   = rst_n & stall_raw;
  assign nop     = rst_n & nop_raw;
  assign fwd_sel = rst_n ? fwd_raw : '0;

  // Next-state: the remaining load bubbles are counted in cnt while in LWAIT
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    if (flush) begin
      state_d = ST_RUN;
      cnt_d   = 4'd0;
    end else if (!mem_busy) begin
      case (state)
        ST_RUN: begin
          if (luse && (LOAD_LAT > 1)) begin
            state_d = ST_LWAIT;
            cnt_d   = LAT_M1;
          end
        end
        ST_LWAIT: begin
          cnt_d = cnt - 4'd1;
          if (cnt == 4'd1) state_d = ST_RUN;
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
      cnt   <= 4'd0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

`ifdef HAZ_PERF_EN
  // Saturating count of stalled cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= 32'd0;
    end else if (stall && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb/tb_hazard_fwd_unit.sv - directed self-checking bench for hazard_fwd_unit
module tb_hazard_fwd_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  src_addr;
  logic [1:0]  src_used;
  logic [4:0]  ex_rd, mem_rd, wb_rd;
  logic        ex_we, ex_load, mem_we, wb_we, mem_busy, flush;
  logic [3:0]  fwd3, fwd1;
  logic        st3, nop3, st1, nop1;
`ifdef HAZ_PERF_EN
  logic [31:0] sc3, sc1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_fwd_unit #(.REG_AW(5), .NUM_SRC(2), .LOAD_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .src_addr(src_addr), .src_used(src_used),
    .ex_rd(ex_rd), .ex_we(ex_we), .ex_load(ex_load),
    .mem_rd(mem_rd), .mem_we(mem_we), .wb_rd(wb_rd), .wb_we(wb_we),
    .mem_busy(mem_busy), .flush(flush),
    .fwd_sel(fwd3), .stall(st3), .nop(nop3)
`ifdef HAZ_PERF_EN
    , .stall_cycles(sc3)
`endif
  );

  hazard_fwd_unit #(.REG_AW(5), .NUM_SRC(2), .LOAD_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .src_addr(src_addr), .src_used(src_used),
    .ex_rd(ex_rd), .ex_we(ex_we), .ex_load(ex_load),
    .mem_rd(mem_rd), .mem_we(mem_we), .wb_rd(wb_rd), .wb_we(wb_we),
    .mem_busy(mem_busy), .flush(flush),
    .fwd_sel(fwd1), .stall(st1), .nop(nop1)
`ifdef HAZ_PERF_EN
    , .stall_cycles(sc1)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    src_addr = '0; src_used = '0;
    ex_rd = '0; ex_we = 0; ex_load = 0;
    mem_rd = '0; mem_we = 0; wb_rd = '0; wb_we = 0;
    mem_busy = 0; flush = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load in EX writing r5, ID instruction reads r5 on operand 1
  task automatic load_use();
    clear_in();
    src_addr = {5'd5, 5'd0}; src_used = 2'b10;
    ex_rd = 5'd5; ex_we = 1; ex_load = 1;
  endtask

  initial begin
    // Reset: outputs zero even with a live load-use pattern on the inputs
    rst_n = 0;
    load_use();
    #12;
    chk("rst_stall", st3, 0);
    chk("rst_nop", nop3, 0);
    chk("rst_fwd", fwd3, 0);
`ifdef HAZ_PERF_EN
    chk("rst_perf", sc3, 0);
`endif
    clear_in();
    @(negedge clk);
    rst_n = 1;
    tick();

    // T1 forwarding priority
    src_addr = {5'd0, 5'd3}; src_used = 2'b01;
    ex_rd = 3; mem_rd = 3; wb_rd = 3; ex_we = 1; mem_we = 1; wb_we = 1;
    #1 chk("t1_ex", fwd3, 4'b0001);
    chk("t1_stall", st3, 0);
    ex_we = 0;
    #1 chk("t1_mem", fwd3, 4'b0010);
    mem_we = 0;
    #1 chk("t1_wb", fwd3, 4'b0011);
    src_addr = {5'd3, 5'd3}; src_used = 2'b11;
    #1 chk("t1_both_wb", fwd3, 4'b1111);
    wb_we = 0;
    #1 chk("t1_none", fwd3, 4'b0000);

    // T2 GR0 never matches; unused operand causes no stall
    clear_in();
    src_addr = {5'd0, 5'd0}; src_used = 2'b01;
    ex_rd = 0; ex_we = 1; ex_load = 1;
    #1 chk("t2_gr0_fwd", fwd3, 0);
    chk("t2_gr0_stall", st3, 0);
    src_addr = {5'd7, 5'd0}; src_used = 2'b01; ex_rd = 7;
    #1 chk("t2_unused_stall", st3, 0);
    chk("t2_unused_fwd", fwd3, 0);
    tick();

    // T3 load-use with LOAD_LAT=3 (and LOAD_LAT=1 on the second instance)
    load_use();
    #1 chk("t3_c1_stall", st3, 1);
    chk("t3_c1_nop", nop3, 1);
    chk("t3_c1_fwd", fwd3[3:2], 2'b01);
    chk("t3_l1_stall", st1, 1);
    tick();
    ex_we = 0; ex_load = 0; mem_rd = 5; mem_we = 1;
    #1 chk("t3_c2_stall", st3, 1);
    chk("t3_c2_nop", nop3, 1);
    chk("t3_l1_c2_stall", st1, 0);
    chk("t3_l1_c2_fwd", fwd1[3:2], 2'b10);
    tick();
    mem_we = 0; wb_rd = 5; wb_we = 1;
    #1 chk("t3_c3_stall", st3, 1);
    chk("t3_c3_nop", nop3, 1);
    tick();
    wb_we = 0; mem_rd = 5; mem_we = 1;
    #1 chk("t3_c4_stall", st3, 0);
    chk("t3_c4_nop", nop3, 0);
    chk("t3_c4_fwd", fwd3[3:2], 2'b10);
    clear_in();
    tick();

    // T4 mem_busy for two cycles starting in the second stall cycle
    load_use();
    #1 chk("t4_c1", {st3, nop3}, 2'b11);
    tick();
    ex_we = 0; ex_load = 0; mem_busy = 1;
    #1 chk("t4_c2", {st3, nop3}, 2'b10);
    tick();
    #1 chk("t4_c3", {st3, nop3}, 2'b10);
    tick();
    mem_busy = 0;
    #1 chk("t4_c4", {st3, nop3}, 2'b11);
    tick();
    #1 chk("t4_c5", {st3, nop3}, 2'b11);
    tick();
    #1 chk("t4_c6", {st3, nop3}, 2'b00);
    tick();

    // T5 flush in the second stall cycle
    load_use();
    #1 chk("t5_c1", {st3, nop3}, 2'b11);
    tick();
    ex_we = 0; ex_load = 0; flush = 1;
    #1 chk("t5_c2", {st3, nop3}, 2'b01);
    tick();
    flush = 0;
    #1 chk("t5_c3", {st3, nop3}, 2'b00);
    tick();

    // flush together with mem_busy: flush wins
    load_use();
    #1 chk("t5b_c1", {st3, nop3}, 2'b11);
    tick();
    ex_we = 0; ex_load = 0; flush = 1; mem_busy = 1;
    #1 chk("t5b_c2", {st3, nop3}, 2'b01);
    tick();
    flush = 0; mem_busy = 0;
    #1 chk("t5b_c3", {st3, nop3}, 2'b00);
    tick();

    // T6 asynchronous reset in the middle of LWAIT
    load_use();
    tick();
    ex_we = 0; ex_load = 0; mem_rd = 5; mem_we = 1;
    #1 chk("t6_lwait", {st3, nop3}, 2'b11);
    chk("t6_fwd_pre", fwd3[3:2], 2'b10);
    #2 rst_n = 0;
    #1 chk("t6_rst_out", {st3, nop3}, 2'b00);
    chk("t6_rst_fwd", fwd3, 0);
`ifdef HAZ_PERF_EN
    chk("t6_rst_perf", sc3, 0);
`endif
    clear_in();
    @(negedge clk);
    rst_n = 1;
    tick();
    #1 chk("t6_after", {st3, nop3}, 2'b00);

`ifdef HAZ_PERF_EN
    // T3 alone from reset gives three counted stall cycles
    load_use();
    tick();
    ex_we = 0; ex_load = 0;
    tick();
    tick();
    #1 chk("t6_perf", sc3, 3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
